// File: rtl/puf_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_test_pkg
// Description : Shared types and helpers for the PUF / NIST test controller.
//               Holds the controller state encoding, the response-mode codes
//               and a saturating increment used by the pass accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FEED  = 3'd3,
        ST_EVAL  = 3'd4,
        ST_STORE = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    localparam logic MODE_XOR = 1'b0;
    localparam logic MODE_RAW = 1'b1;

    // Adds inc to a, holding at max_val once reached.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic        inc,
                                            input logic [31:0] max_val);
        if (inc && (a < max_val)) begin
            return a + 32'd1;
        end
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pass_accum.sv
`default_nettype none
// ============================================================================
// Module      : pass_accum
// Description : N_TESTS saturating pass counters. clr zeroes all counters,
//               en adds res[i] into counter i, rd_idx selects the counter
//               shown on rd_data.
// Ports       : clk_1, rst          - clock, synchronous active-high reset
//               clr, en, res        - clear, accumulate enable, pass flags
//               rd_idx, rd_data     - indexed read port
// Revision    : 1.0 - initial release
// ============================================================================
module pass_accum
    import puf_test_pkg::*;
#(
    parameter int N_TESTS = 8,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = $clog2(N_TESTS + 1)
) (
    input  logic               clk_1,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [N_TESTS-1:0] res,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [CNT_W-1:0]   rd_data
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] cnt [N_TESTS];

    for (genvar i = 0; i < N_TESTS; i++) begin : g_cnt
        always_ff @(posedge clk_1) begin
            if (rst || clr) begin
                cnt[i] <= '0;
            end else if (en) begin
                cnt[i] <= CNT_W'(sat_add(32'(cnt[i]), res[i], CNT_MAX));
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_TESTS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = cnt[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/puf_nist_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : puf_nist_test_ctrl
// Description : Drives a PUF with generator challenges, streams the response
//               bits (one xor bit or two raw bits per challenge) to a NIST
//               test block, accumulates per-test pass counts over N_ROUNDS
//               rounds and writes them to result memory at base_addr.
// Ports       : start/mode/base_addr -> busy/done/err    run handshake
//               chal_in, puf_*                            PUF interface
//               test_bit(_vld), test_res(_vld)            NIST interface
//               mem_we/mem_waddr/mem_din                  result memory
// Revision    : 1.0 - initial release
// ============================================================================
module puf_nist_test_ctrl
    import puf_test_pkg::*;
#(
    parameter int N_CB       = 64,
    parameter int N_TESTS    = 8,
    parameter int ROUND_BITS = 20000,
    parameter int N_ROUNDS   = 255,
    parameter int CNT_W      = 8,
    parameter int ADDR_W     = 13,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk_1,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic [N_CB-1:0]    chal_in,
    output logic [N_CB-1:0]    puf_challenge,
    output logic               puf_trigger,
    input  logic               puf_done,
    input  logic               puf_xor,
    input  logic [1:0]         puf_raw,
    output logic               test_bit,
    output logic               test_bit_vld,
    input  logic [N_TESTS-1:0] test_res,
    input  logic               test_res_vld,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [CNT_W-1:0]   mem_din
);

    localparam int BIT_W = $clog2(ROUND_BITS + 1);
    localparam int RND_W = $clog2(N_ROUNDS + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int IDX_W = $clog2(N_TESTS + 1);

    state_t             state;
    logic               mode_r;
    logic [ADDR_W-1:0]  base_r;
    logic [BIT_W-1:0]   bit_cnt;
    logic [RND_W-1:0]   round_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               raw_hi;     // second raw bit, held for the mode-1 second FEED cycle
    logic               second;     // FEED is on the second bit of a challenge
    logic [IDX_W-1:0]   store_idx;

    logic               acc_clr;
    logic               acc_en;

    assign acc_clr = (state == ST_IDLE) && start;
    assign acc_en  = (state == ST_EVAL) && test_res_vld;

    // mem_din is a mux of registered counters indexed by a registered index,
    // so it is stable for the whole write cycle.
    pass_accum #(
        .N_TESTS (N_TESTS),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_accum (
        .clk_1   (clk_1),
        .rst     (rst),
        .clr     (acc_clr),
        .en      (acc_en),
        .res     (test_res),
        .rd_idx  (store_idx),
        .rd_data (mem_din)
    );

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state         <= ST_IDLE;
            mode_r        <= MODE_XOR;
            base_r        <= '0;
            bit_cnt       <= '0;
            round_cnt     <= '0;
            to_cnt        <= '0;
            raw_hi        <= 1'b0;
            second        <= 1'b0;
            store_idx     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            puf_challenge <= '0;
            puf_trigger   <= 1'b0;
            test_bit      <= 1'b0;
            test_bit_vld  <= 1'b0;
            mem_we        <= 1'b0;
            mem_waddr     <= '0;
        end else begin
            puf_trigger <= 1'b0;
            done        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r        <= mode;
                        base_r        <= base_addr;
                        bit_cnt       <= '0;
                        round_cnt     <= '0;
                        err           <= 1'b0;
                        busy          <= 1'b1;
                        puf_challenge <= chal_in;
                        puf_trigger   <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A response arriving on the final counted cycle still wins.
                    if (puf_done) begin
                        raw_hi       <= puf_raw[1];
                        test_bit     <= (mode_r == MODE_RAW) ? puf_raw[0] : puf_xor;
                        test_bit_vld <= 1'b1;
                        second       <= 1'b0;
                        state        <= ST_FEED;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                ST_FEED: begin
                    if (bit_cnt == BIT_W'(ROUND_BITS - 1)) begin
                        // Round complete; a pending second raw bit is dropped.
                        bit_cnt      <= '0;
                        test_bit_vld <= 1'b0;
                        state        <= ST_EVAL;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if ((mode_r == MODE_RAW) && !second) begin
                            second   <= 1'b1;
                            test_bit <= raw_hi;
                        end else begin
                            test_bit_vld  <= 1'b0;
                            puf_challenge <= chal_in;
                            puf_trigger   <= 1'b1;
                            state         <= ST_ISSUE;
                        end
                    end
                end

                ST_EVAL: begin
                    if (test_res_vld) begin
                        round_cnt <= round_cnt + RND_W'(1);
                        if (round_cnt == RND_W'(N_ROUNDS - 1)) begin
                            store_idx <= '0;
                            mem_we    <= 1'b1;
                            mem_waddr <= base_r;
                            state     <= ST_STORE;
                        end else begin
                            puf_challenge <= chal_in;
                            puf_trigger   <= 1'b1;
                            state         <= ST_ISSUE;
                        end
                    end
                end

                ST_STORE: begin
                    if (store_idx == IDX_W'(N_TESTS - 1)) begin
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_FIN;
                    end else begin
                        store_idx <= store_idx + IDX_W'(1);
                        mem_waddr <= mem_waddr + ADDR_W'(1);
                    end
                end

                ST_FIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
